// File: rtl/negcap_pkg.sv
// Shared types and helpers for the negedge capture sequencer.
// State encoding, default sizes and a saturating counter step.
package negcap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    CHKRST,
    SETUP,
    FALL,
    SAMPLE,
    DONE
  } state_e;

  localparam int DEF_DATA_W   = 7;
  localparam int DEF_ITER_W   = 8;
  localparam int DEF_HOLD_CYC = 2;
  localparam int DEF_RST_CYC  = 2;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] maxv
  );
    return (v >= maxv) ? maxv : v + 32'd1;
  endfunction

endpackage

// File: rtl/negcap_phase_timer.sv
// Load/count-down phase counter shared by the timed states.
// expire_o is high once the loaded count has run down to zero.
module negcap_phase_timer #(
  parameter int W = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expire_o
);

  logic [W-1:0] cnt_q;

  // Load on phase entry, then count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/negedge_capture_sequencer.sv
// Drives a negedge-clocked capture register through reset and N
// load/compare iterations, counting mismatches on its output.
module negedge_capture_sequencer
  import negcap_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ITER_W   = DEF_ITER_W,
  parameter int HOLD_CYC = DEF_HOLD_CYC,
  parameter int RST_CYC  = DEF_RST_CYC
) (
  input  logic              clkin_data,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ITER_W-1:0] num_iter,
  input  logic [DATA_W-1:0] seed_data,
  output logic              busy,
  output logic              done,
  output logic              dut_clk,
  output logic              dut_rst,
  output logic [DATA_W-1:0] dut_d,
  input  logic [DATA_W-1:0] dut_q,
  output logic              mismatch,
  output logic [ITER_W-1:0] mismatch_cnt,
  output logic [DATA_W-1:0] last_bad
);

  localparam int MAXC = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0] RST_LD  = TW'(RST_CYC - 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [ITER_W-1:0] CNT_ALL = '1;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] n_q;
  logic [DATA_W-1:0] seed_q;
  logic [ITER_W-1:0] iter_q;
  logic [ITER_W-1:0] iter_nx;
  logic [ITER_W-1:0] iter_set;
  logic              busy_q;
  logic              done_q;
  logic              dut_clk_q;
  logic              dut_rst_q;
  logic [DATA_W-1:0] dut_d_q;
  logic              mm_q;
  logic [ITER_W-1:0] cnt_q;
  logic [DATA_W-1:0] lb_q;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_exp;
  logic              fail;

  negcap_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk_i      (clkin_data),
    .rst_n_i    (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  // Next state, timer loads on phase entry, and compare result.
  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    iter_nx  = iter_q + 1'b1;
    iter_set = (state_q == SAMPLE) ? iter_nx : '0;
    fail     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RESET;
          tmr_load = 1'b1;
          tmr_val  = RST_LD;
        end
      end
      RESET: begin
        if (tmr_exp) state_d = CHKRST;
      end
      CHKRST: begin
        fail = (dut_q != '0);
        if (n_q == '0) begin
          state_d = DONE;
        end else begin
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      SETUP: begin
        if (tmr_exp) begin
          state_d  = FALL;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      FALL: begin
        if (tmr_exp) state_d = SAMPLE;
      end
      SAMPLE: begin
        fail = (dut_q != dut_d_q);
        if (iter_nx == n_q) begin
          state_d = DONE;
        end else begin
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, registered DUT drive and result bookkeeping.
  always_ff @(posedge clkin_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      seed_q    <= '0;
      iter_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dut_clk_q <= 1'b1;
      dut_rst_q <= 1'b1;
      dut_d_q   <= '0;
      mm_q      <= 1'b0;
      cnt_q     <= '0;
      lb_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
      dut_clk_q <= !((state_d == FALL) || (state_d == SAMPLE));
      dut_rst_q <= (state_d == RESET);
      if ((state_q == IDLE) && start) begin
        n_q    <= num_iter;
        seed_q <= seed_data;
        mm_q   <= 1'b0;
        cnt_q  <= '0;
        lb_q   <= '0;
      end
      if (fail) begin
        mm_q  <= 1'b1;
        cnt_q <= ITER_W'(sat_inc(32'(cnt_q), 32'(CNT_ALL)));
        lb_q  <= dut_q;
      end
      if ((state_q == CHKRST) || (state_q == SAMPLE)) begin
        iter_q <= iter_set;
      end
      if ((state_d == SETUP) && (state_q != SETUP)) begin
        dut_d_q <= seed_q + DATA_W'(iter_set);
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign dut_clk      = dut_clk_q;
  assign dut_rst      = dut_rst_q;
  assign dut_d        = dut_d_q;
  assign mismatch     = mm_q;
  assign mismatch_cnt = cnt_q;
  assign last_bad     = lb_q;

endmodule

// File: tb/tb_negedge_capture_sequencer.sv
// Scoreboard bench: a modelled capture register with selectable faults,
// expected edges/results queued at start, checked by a monitor.
module tb_negedge_capture_sequencer;

  localparam int DW   = 7;
  localparam int IW   = 8;
  localparam int HOLD = 2;
  localparam int RSTC = 2;

  typedef struct {
    int          busy;
    logic        mm;
    logic [IW-1:0] cnt;
    logic [DW-1:0] lb;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] num_iter = '0;
  logic [DW-1:0] seed_data = '0;
  logic          busy, done, dut_clk, dut_rst, mismatch;
  logic [DW-1:0] dut_d, dut_q, last_bad;
  logic [IW-1:0] mismatch_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int mode = 0;

  res_t          res_q[$];
  logic [DW-1:0] dat_q[$];

  negedge_capture_sequencer dut (
    .clkin_data   (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_iter     (num_iter),
    .seed_data    (seed_data),
    .busy         (busy),
    .done         (done),
    .dut_clk      (dut_clk),
    .dut_rst      (dut_rst),
    .dut_d        (dut_d),
    .dut_q        (dut_q),
    .mismatch     (mismatch),
    .mismatch_cnt (mismatch_cnt),
    .last_bad     (last_bad)
  );

  always #5 clk = ~clk;

  // Capture register under check; mode selects a fault behaviour.
  logic [DW-1:0] cap_q;
  always @(negedge dut_clk or posedge dut_rst) begin
    if (dut_rst) cap_q <= '0;
    else cap_q <= (mode == 2) ? (dut_d ^ 7'h01) : dut_d;
  end
  assign dut_q = (mode == 1) ? 7'h00 :
                 (mode == 3) ? 7'h55 :
                 (mode == 4) ? (cap_q ^ 7'h7F) : cap_q;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_q(input int m, input logic [DW-1:0] d);
    case (m)
      1: return 7'h00;
      2: return d ^ 7'h01;
      3: return 7'h55;
      4: return d ^ 7'h7F;
      default: return d;
    endcase
  endfunction

  function automatic res_t model(input int m, input int n, input logic [DW-1:0] s);
    res_t r;
    int f;
    logic [DW-1:0] d, q;
    f = 0;
    r.lb = '0;
    r.busy = RSTC + 1 + n * (2 * HOLD + 1) + 1;
    q = (m == 3) ? 7'h55 : (m == 4) ? 7'h7F : 7'h00;
    if (q != 0) begin f++; r.lb = q; end
    for (int k = 0; k < n; k++) begin
      d = s + DW'(k);
      q = model_q(m, d);
      if (q != d) begin f++; r.lb = q; end
    end
    r.cnt = (f > 255) ? 8'hFF : IW'(f);
    r.mm = (f > 0);
    return r;
  endfunction

  // Monitor: busy-cycle count, capture-edge data and end-of-run results.
  int   bc = 0;
  logic prev_dc = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      bc = 0;
    end else begin
      if (busy) bc++;
      else bc = 0;
      if (prev_dc && !dut_clk) begin
        if (dat_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_edge: got dut_d=%0h with no edge expected", dut_d);
        end else begin
          chk("dut_d", dut_d, dat_q.pop_front());
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected no run");
        end else begin
          res_t e;
          e = res_q.pop_front();
          chk("busy_cycles", bc, e.busy);
          chk("mismatch", mismatch, e.mm);
          chk("mismatch_cnt", mismatch_cnt, e.cnt);
          chk("last_bad", last_bad, e.lb);
          chk("edges_left", dat_q.size(), 0);
        end
      end
    end
    prev_dc = dut_clk;
  end

  task automatic run(input int n, input logic [DW-1:0] s, input int m,
                     input bit start_in_done);
    bit got;
    @(negedge clk);
    mode = m;
    res_q.push_back(model(m, n, s));
    for (int k = 0; k < n; k++) dat_q.push_back(s + DW'(k));
    num_iter = IW'(n);
    seed_data = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    num_iter = IW'($urandom);
    seed_data = DW'($urandom);
    got = 1'b0;
    for (int c = 0; c < 5 * n + 40 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        start = start_in_done;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", busy, 0);
      end else begin
        start = ($urandom_range(0, 7) == 0);
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: got no done expected done within budget");
      res_q.delete();
      dat_q.delete();
    end
  endtask

  initial begin
    int falls;
    logic pdc;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dut_clk", dut_clk, 1);
    chk("rst_dut_rst", dut_rst, 1);
    chk("rst_dut_d", dut_d, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_cnt", mismatch_cnt, 0);
    chk("rst_last_bad", last_bad, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_dut_rst", dut_rst, 0);
    chk("idle_dut_clk", dut_clk, 1);

    run(3, 7'h10, 0, 1'b0);
    run(3, 7'h05, 1, 1'b0);
    run(0, DW'($urandom), 0, 1'b1);
    run(3, 7'h7E, 0, 1'b0);
    run(3, 7'h05, 2, 1'b1);
    run(255, 7'h01, 4, 1'b0);
    run(3, 7'h22, 4, 1'b0);
    run(130, 7'h40, 3, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run($urandom_range(0, 12), DW'($urandom), $urandom_range(0, 4),
          1'($urandom));
    end

    // Reset pulled during the second capture phase.
    @(negedge clk);
    mode = 0;
    for (int k = 0; k < 4; k++) dat_q.push_back(7'h30 + DW'(k));
    num_iter = 8'd4;
    seed_data = 7'h30;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    falls = 0;
    pdc = dut_clk;
    for (int c = 0; c < 200 && falls < 2; c++) begin
      @(negedge clk);
      if (pdc && !dut_clk) falls++;
      pdc = dut_clk;
    end
    chk("second_fall_reached", falls, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_dut_rst", dut_rst, 1);
    chk("midrst_dut_clk", dut_clk, 1);
    chk("midrst_busy", busy, 0);
    dat_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnt", mismatch_cnt, 0);
    chk("post_rst_dut_clk", dut_clk, 1);
    repeat (5) @(negedge clk);
    chk("post_rst_stays_idle", busy, 0);
    run(5, 7'h7C, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("results_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/negedge_capture_sequencer.md
Name: negedge_capture_sequencer

Overview:
- Self-checking stimulus sequencer for a negedge-clocked capture register with an active-high async reset. That register is the device under check (DUT), held in reset and loaded on a falling strobe.
- Per run: pulses the DUT reset, confirms the DUT output is zero, then runs N iterations. Each iteration drives data, makes a deliberate high→low strobe edge, samples the DUT output and compares it to the driven data.
- Sits beside the DUT in fuzz-regression harnesses. Reports pass/fail without an external golden model.

Parameters:
- DATA_W, 7, DUT data width.
- ITER_W, 8, iteration-count and mismatch-counter width.
- HOLD_CYC, 2, cycles in each strobe phase (high phase, then low phase); must be ≥1.
- RST_CYC, 2, cycles the DUT reset is held high; must be ≥1.

Ports:
- clkin_data  in  1  controller clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- num_iter  in  ITER_W  iteration count; latched on accepted start.
- seed_data  in  DATA_W  base data value; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of run.
- dut_clk  out  1  strobe to DUT; DUT captures on its falling edge.
- dut_rst  out  1  active-high async reset to DUT.
- dut_d  out  DATA_W  data to DUT.
- dut_q  in  DATA_W  DUT register output.
- mismatch  out  1  sticky; set on any failed compare in the current run.
- mismatch_cnt  out  ITER_W  failed compares in the current run; saturates at all-ones.
- last_bad  out  DATA_W  dut_q value of the most recent failed compare.

Behaviour:
- All outputs are registered.
- Reset values (rst_n low, asynchronous):
  - state=IDLE, busy=0, done=0.
  - dut_clk=1, so no spurious falling edge occurs on reset exit.
  - dut_rst=1, so the DUT is held in reset while the controller is in reset.
  - dut_d=0, mismatch=0, mismatch_cnt=0, last_bad=0.
- IDLE:
  - dut_clk=1, dut_rst=0.
  - On start=1: latch num_iter and seed_data, clear mismatch, mismatch_cnt and last_bad, go to RESET.
- RESET: dut_rst=1 for RST_CYC cycles, then go to CHKRST.
- CHKRST (1 cycle):
  - dut_rst=0.
  - At the cycle end, compare dut_q to 0; a failure counts as a mismatch.
  - If latched num_iter=0, go to DONE; else set iter=0 and go to SETUP.
- SETUP (HOLD_CYC cycles): dut_clk=1, dut_d = (seed + iter) mod 2^DATA_W, then go to FALL.
- FALL (HOLD_CYC cycles):
  - dut_clk=0; the 1→0 transition on entering FALL is the capture edge.
  - dut_d is held stable throughout.
  - Go to SAMPLE.
- SAMPLE (1 cycle):
  - dut_clk=0.
  - Compare dut_q to dut_d.
  - Increment iter; if iter = num_iter, go to DONE, else go to SETUP.
  - SAMPLE→SETUP raises dut_clk; this rising edge must not capture in the DUT.
- DONE (1 cycle): done=1, dut_clk=1, then go to IDLE. Results hold until the next accepted start.
- Failed compare: mismatch←1; mismatch_cnt←min(cnt+1, 2^ITER_W−1); last_bad←dut_q.
- Run length in busy cycles: RST_CYC + 1 + num_iter·(2·HOLD_CYC+1) + 1.
- start while busy is ignored; a start asserted in the DONE cycle is also ignored.
- The dut_d wrap-around is modular: seed=7'h7F, iter=1 gives 7'h00.
- rst_n asserted mid-run: immediate return to reset values. Restart requires a new start.
- rst_n deasserted: the first cycle is IDLE; no DUT edge is generated until start.

Decomposition:
- Package negcap_pkg contains:
  - state enum: IDLE, RESET, CHKRST, SETUP, FALL, SAMPLE, DONE;
  - default parameter constants;
  - saturating-increment function.
- One sub-module, negcap_phase_timer: a load/count-down phase counter with an expire flag, shared by RESET, SETUP and FALL.
- The FSM, iteration counter and compare logic live in the top module.

Test Plan (defaults unless stated):
- Ideal DUT model; start with num_iter=3, seed=7'h10 → dut_d=10,11,12 on three falling edges; mismatch=0, cnt=0; busy high for exactly 19 cycles; done pulses once.
- DUT model that ignores negedges (output stuck at 0); num_iter=3, seed=7'h05 → mismatch=1, cnt=3, last_bad=7'h00.
- num_iter=0 → RESET 2 cycles, CHKRST, DONE; no falling edge on dut_clk; busy 4 cycles; mismatch=0.
- seed=7'h7E, num_iter=3 → dut_d sequence 7E,7F,00; ideal DUT gives no mismatch.
- rst_n pulled low during the second FALL → dut_rst=1 and dut_clk=1 immediately; after release state is IDLE, busy=0, cnt=0; a second start runs cleanly.
- ITER_W=2; always-failing DUT; num_iter=3 → cnt=3 with saturation held. Repeat with num_iter=3 after a prior run → counters cleared at start. Start pulsed while busy → no effect on the run length.
